// File: rtl/sequenciador_leds_pkg.sv
// Shared state codes and default timing for the LED sequence player.
package sequenciador_leds_pkg;

   // 5-bit state codes, also shown on the hex debug display
   localparam logic [4:0] EST_INICIAL = 5'd0;
   localparam logic [4:0] EST_PREPARA = 5'd1;
   localparam logic [4:0] EST_LE_MEM  = 5'd2;
   localparam logic [4:0] EST_ACENDE  = 5'd3;
   localparam logic [4:0] EST_APAGA   = 5'd4;
   localparam logic [4:0] EST_FIM     = 5'd6;

   localparam int unsigned T_ACESO_PADRAO   = 500;
   localparam int unsigned T_APAGADO_PADRAO = 250;

   typedef enum logic [4:0] {
      INICIAL = EST_INICIAL,
      PREPARA = EST_PREPARA,
      LE_MEM  = EST_LE_MEM,
      ACENDE  = EST_ACENDE,
      APAGA   = EST_APAGA,
      FIM     = EST_FIM
   } estado_t;

   // Larger of two cycle counts, used to size the shared timer
   function automatic int unsigned maximo(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sequenciador_leds_contador_temporizador.sv
// Up-counter with synchronous clear that stops at a programmable terminal value.
module contador_temporizador #(
   parameter int unsigned W = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         i_zera,
   input  logic         i_conta,
   input  logic [W-1:0] i_m,
   output logic         o_fim_c
);

   logic [W-1:0] r_valor;

   assign o_fim_c = (r_valor == i_m);

   // Clear has priority; counting saturates at the terminal value
   always_ff @(posedge clock) begin
      if (reset) begin
         r_valor <= '0;
      end else if (i_zera) begin
         r_valor <= '0;
      end else if (i_conta && !o_fim_c) begin
         r_valor <= r_valor + W'(1);
      end
   end

endmodule

// File: rtl/sequenciador_leds.sv
// Plays the stored game sequence on the LEDs, one entry per on/off period.
module sequenciador_leds
   import sequenciador_leds_pkg::*;
#(
   parameter int unsigned T_ACESO   = T_ACESO_PADRAO,
   parameter int unsigned T_APAGADO = T_APAGADO_PADRAO,
   parameter int unsigned W_ADDR    = 4,
   parameter int unsigned W_DADO    = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              iniciar,
   input  logic              cancelar,
   input  logic [W_ADDR-1:0] rodada,
   input  logic [W_DADO-1:0] dado_memoria,
   output logic [W_ADDR-1:0] endereco,
   output logic [W_DADO-1:0] leds,
   output logic              ocupado,
   output logic              pronto,
   output logic [4:0]        db_estado
);

   localparam int unsigned T_MAX = maximo(T_ACESO, T_APAGADO);
   localparam int unsigned W_T   = (T_MAX > 1) ? $clog2(T_MAX) : 1;

   estado_t           r_estado;
   estado_t           w_prox;
   logic [W_ADDR-1:0] r_endereco;
   logic [W_ADDR-1:0] r_rodada;
   logic [W_DADO-1:0] r_leds;
   logic              r_ocupado;
   logic              r_pronto;

   logic              w_zera;
   logic              w_conta;
   logic              w_fim;
   logic [W_T-1:0]    w_m;
   logic              w_end_zera;
   logic              w_end_inc;
   logic              w_leds_carrega;
   logic              w_leds_zera;
   logic              w_rodada_carrega;

   // Terminal count depends on whether the LED is in its on or off phase
   assign w_m = (r_estado == ACENDE) ? W_T'(T_ACESO - 1) : W_T'(T_APAGADO - 1);

   contador_temporizador #(
      .W (W_T)
   ) u_timer (
      .clock   (clock),
      .reset   (reset),
      .i_zera  (w_zera),
      .i_conta (w_conta),
      .i_m     (w_m),
      .o_fim_c (w_fim)
   );

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         r_estado <= INICIAL;
      end else begin
         r_estado <= w_prox;
      end
   end

   // Next-state and datapath control
   always_comb begin
      w_prox           = r_estado;
      w_zera           = 1'b0;
      w_conta          = 1'b0;
      w_end_zera       = 1'b0;
      w_end_inc        = 1'b0;
      w_leds_carrega   = 1'b0;
      w_leds_zera      = 1'b0;
      w_rodada_carrega = 1'b0;
      case (r_estado)
         INICIAL: begin
            w_leds_zera = 1'b1;
            if (iniciar && !cancelar) begin
               w_rodada_carrega = 1'b1;
               w_prox           = PREPARA;
            end
         end
         PREPARA: begin
            w_end_zera = 1'b1;
            w_zera     = 1'b1;
            w_prox     = LE_MEM;
         end
         LE_MEM: begin
            w_leds_carrega = 1'b1;
            w_zera         = 1'b1;
            w_prox         = ACENDE;
         end
         ACENDE: begin
            w_conta = 1'b1;
            if (w_fim) begin
               w_leds_zera = 1'b1;
               w_zera      = 1'b1;
               w_prox      = APAGA;
            end
         end
         APAGA: begin
            w_conta = 1'b1;
            if (w_fim) begin
               w_zera = 1'b1;
               if (r_endereco == r_rodada) begin
                  w_prox = FIM;
               end else begin
                  w_end_inc = 1'b1;
                  w_prox    = LE_MEM;
               end
            end
         end
         FIM: begin
            w_prox = INICIAL;
         end
         default: begin
            w_leds_zera = 1'b1;
            w_zera      = 1'b1;
            w_prox      = INICIAL;
         end
      endcase
      // Abort wins over everything except the idle state
      if (cancelar && (r_estado != INICIAL)) begin
         w_prox         = INICIAL;
         w_leds_zera    = 1'b1;
         w_leds_carrega = 1'b0;
         w_zera         = 1'b1;
         w_conta        = 1'b0;
         w_end_zera     = 1'b0;
         w_end_inc      = 1'b0;
      end
   end

   // Address, LED, latched round and Moore status registers
   always_ff @(posedge clock) begin
      if (reset) begin
         r_endereco <= '0;
         r_rodada   <= '0;
         r_leds     <= '0;
         r_ocupado  <= 1'b0;
         r_pronto   <= 1'b0;
      end else begin
         if (w_end_zera) begin
            r_endereco <= '0;
         end else if (w_end_inc) begin
            r_endereco <= r_endereco + W_ADDR'(1);
         end
         if (w_rodada_carrega) begin
            r_rodada <= rodada;
         end
         if (w_leds_carrega) begin
            r_leds <= dado_memoria;
         end else if (w_leds_zera) begin
            r_leds <= '0;
         end
         r_ocupado <= (w_prox == PREPARA) || (w_prox == LE_MEM) ||
                      (w_prox == ACENDE)  || (w_prox == APAGA);
         r_pronto  <= (w_prox == FIM);
      end
   end

   assign endereco  = r_endereco;
   assign leds      = r_leds;
   assign ocupado   = r_ocupado;
   assign pronto    = r_pronto;
   assign db_estado = r_estado;

endmodule

// File: tb/tb_sequenciador_leds.sv
// Scoreboard bench for sequenciador_leds with short on/off times.
module tb_sequenciador_leds;

   localparam int unsigned TA  = 3;
   localparam int unsigned TP  = 2;
   localparam int unsigned PER = 1 + TA + TP;

   typedef struct {
      logic [3:0] leds;
      logic [3:0] endereco;
      logic       ocupado;
      logic       pronto;
      logic [4:0] estado;
      int         cen;
      int         ciclo;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       iniciar = 1'b0;
   logic       cancelar = 1'b0;
   logic [3:0] rodada = '0;
   logic [3:0] dado_memoria = '0;
   logic [3:0] endereco;
   logic [3:0] leds;
   logic       ocupado;
   logic       pronto;
   logic [4:0] db_estado;

   logic [3:0] ram [16];
   exp_t       fila[$];
   int         checks = 0;
   int         failures = 0;
   logic [3:0] end_ant = '0;

   sequenciador_leds #(
      .T_ACESO   (TA),
      .T_APAGADO (TP),
      .W_ADDR    (4),
      .W_DADO    (4)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .iniciar      (iniciar),
      .cancelar     (cancelar),
      .rodada       (rodada),
      .dado_memoria (dado_memoria),
      .endereco     (endereco),
      .leds         (leds),
      .ocupado      (ocupado),
      .pronto       (pronto),
      .db_estado    (db_estado)
   );

   always #5 clock = ~clock;

   // RAM model: data for the current address is available within the same cycle
   always @(negedge clock) dado_memoria <= ram[endereco];

   // Monitor: one expected output vector per cycle
   always @(negedge clock) begin
      if (fila.size() > 0) begin
         exp_t e;
         #1;
         e = fila.pop_front();
         checks++;
         if (leds !== e.leds || endereco !== e.endereco || ocupado !== e.ocupado ||
             pronto !== e.pronto || db_estado !== e.estado) begin
            failures++;
            $display("FAIL saida cen%0d ciclo%0d: got leds=%b end=%0d oc=%b pr=%b est=%0d exp leds=%b end=%0d oc=%b pr=%b est=%0d",
                     e.cen, e.ciclo, leds, endereco, ocupado, pronto, db_estado,
                     e.leds, e.endereco, e.ocupado, e.pronto, e.estado);
         end
      end
   end

   // Closed-form timeline of one playback of n entries started at cycle 0
   function automatic exp_t esperado(input int c, input int n, input logic [3:0] ant);
      exp_t e;
      e.leds = '0; e.endereco = ant; e.ocupado = 1'b0; e.pronto = 1'b0; e.estado = 5'd0;
      e.cen = 0; e.ciclo = c;
      if (c == 1) begin
         e.estado = 5'd1; e.ocupado = 1'b1;
      end else if (c >= 2 && c < 2 + n * PER) begin
         int k;
         int p;
         k = (c - 2) / PER;
         p = (c - 2) % PER;
         e.endereco = 4'(k);
         e.ocupado  = 1'b1;
         if (p == 0) e.estado = 5'd2;
         else if (p <= TA) begin
            e.estado = 5'd3;
            e.leds   = ram[k];
         end else e.estado = 5'd4;
      end else if (c == 2 + n * PER) begin
         e.estado = 5'd6; e.pronto = 1'b1; e.endereco = 4'(n - 1);
      end else if (c > 2 + n * PER) begin
         e.endereco = 4'(n - 1);
      end
      return e;
   endfunction

   // One playback scenario; optional mid-run iniciar/rodada disturbance and abort
   task automatic tocar(input int cen, input int r, input int cancela_em, input bit perturba);
      int   n;
      int   total;
      exp_t e;
      exp_t e_cancel;
      n = r + 1;
      total = 2 + n * PER + 3;
      e_cancel = esperado(0, n, end_ant);
      for (int c = 0; c < total; c++) begin
         @(posedge clock);
         #1;
         iniciar  = (c == 0) || (perturba && c == 5);
         rodada   = (perturba && c >= 5) ? 4'd0 : 4'(r);
         cancelar = (c == cancela_em);
         if (cancela_em >= 0 && c > cancela_em) begin
            e = e_cancel;
            e.leds = '0; e.ocupado = 1'b0; e.pronto = 1'b0; e.estado = 5'd0;
         end else begin
            e = esperado(c, n, end_ant);
            if (c == cancela_em) e_cancel = e;
         end
         e.cen = cen;
         e.ciclo = c;
         fila.push_back(e);
      end
      end_ant = e.endereco;
      iniciar = 1'b0;
      cancelar = 1'b0;
   endtask

   initial begin
      exp_t e;
      for (int i = 0; i < 16; i++) ram[i] = 4'd0;
      ram[0] = 4'b0001; ram[1] = 4'b0010; ram[2] = 4'b0100;
      repeat (3) @(posedge clock);
      // Reset release followed by 20 idle cycles
      for (int c = 0; c < 20; c++) begin
         @(posedge clock);
         #1;
         reset = 1'b0;
         e = esperado(0, 1, 4'd0);
         e.cen = 0;
         e.ciclo = c;
         fila.push_back(e);
      end
      tocar(1, 0, -1, 1'b0);
      tocar(2, 2, -1, 1'b0);
      tocar(3, 2, -1, 1'b1);
      tocar(4, 2, 10, 1'b0);
      for (int i = 0; i < 16; i++) ram[i] = 4'(i);
      tocar(5, 15, -1, 1'b0);
      repeat (3) @(negedge clock);
      checks++;
      if (fila.size() != 0) begin
         failures++;
         $display("FAIL fila_vazia: got %0d pending exp 0", fila.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
